// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// CON bit positions and the serialiser state encoding.
package uart_pkg;

    localparam logic [31:0] TXD_OFF = 32'h0000_0018;
    localparam logic [31:0] CON_OFF = 32'h0000_0020;

    localparam int CON_IRQEN = 0;
    localparam int CON_DONE  = 2;
    localparam int CON_BUSY  = 3;
    localparam int CON_FULL  = 4;
    localparam int CON_OVF   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serialiser: pulls a byte when ready, shifts it out LSB first and flags
// the last cycle of each stop bit so the caller can record completion.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       tx,
    output logic       frame_done,
    output logic       busy
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

    tx_state_t  state;
    logic [TW-1:0] timer;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       last_tick;
    logic       load;

    assign last_tick  = (timer == LAST_TICK);
    // A byte may be taken while idle or on the final stop-bit cycle, which
    // lets queued frames follow each other with no idle gap.
    assign byte_ready = (state == IDLE) || ((state == STOP) && last_tick);
    assign frame_done = (state == STOP) && last_tick;
    assign busy       = (state != IDLE);
    assign load       = byte_ready && byte_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    timer   <= '0;
                    bit_cnt <= '0;
                    tx      <= 1'b1;
                    if (byte_valid) begin
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (last_tick) begin
                        timer <= '0;
                        state <= DATA;
                        tx    <= shift[0];
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (last_tick) begin
                        timer <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                            tx      <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift[1];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (last_tick) begin
                        timer <= '0;
                        if (byte_valid) begin
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    // Data path: no reset needed, the shifter is always loaded before use.
    always_ff @(posedge clk) begin
        if (load) begin
            shift <= byte_in;
        end else if ((state == DATA) && last_tick) begin
            shift <= {1'b0, shift[7:1]};
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// UART transmitter peripheral on the CPU data bus: address decode, TX FIFO,
// CON status/control register and the serialiser core.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 5208,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] TXD_ADDR = BASE_ADDR + TXD_OFF;
    localparam logic [31:0] CON_ADDR = BASE_ADDR + CON_OFF;

    logic          sel_txd;
    logic          sel_con;
    logic          txd_wr;
    logic          con_wr;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          ovf_set;

    logic          con_irq_en;
    logic          con_done;
    logic          con_ovf;
    logic [31:0]   con_rd;

    logic          core_ready;
    logic          core_done;
    logic          core_busy;
    logic          unused_wdata;

    assign unused_wdata = ^wdata[31:8];

    assign sel_txd = (addr == TXD_ADDR);
    assign sel_con = (addr == CON_ADDR);
    assign txd_wr  = MemWrite && sel_txd;
    assign con_wr  = MemWrite && sel_con;

    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == '0);
    assign pop        = core_ready && !fifo_empty;
    // A same-cycle pop frees a slot, so a store to a full FIFO still lands.
    assign push       = txd_wr && (!fifo_full || pop);
    assign ovf_set    = txd_wr && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wdata[7:0];
        end
    end

    // Completion and overflow are sticky; a hardware set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            con_irq_en <= 1'b0;
            con_done   <= 1'b0;
            con_ovf    <= 1'b0;
        end else begin
            if (con_wr) begin
                con_irq_en <= wdata[CON_IRQEN];
            end
            if (core_done) begin
                con_done <= 1'b1;
            end else if (con_wr && wdata[CON_DONE]) begin
                con_done <= 1'b0;
            end
            if (ovf_set) begin
                con_ovf <= 1'b1;
            end else if (con_wr && wdata[CON_OVF]) begin
                con_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        con_rd            = '0;
        con_rd[CON_IRQEN] = con_irq_en;
        con_rd[CON_DONE]  = con_done;
        con_rd[CON_BUSY]  = core_busy || !fifo_empty;
        con_rd[CON_FULL]  = fifo_full;
        con_rd[CON_OVF]   = con_ovf;
    end

    always_comb begin
        rdata = '0;
        if (MemRead && sel_con) begin
            rdata = con_rd;
        end
    end

    assign irq = con_irq_en && con_done;

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .byte_in   (fifo_mem[rd_ptr]),
        .byte_valid(!fifo_empty),
        .byte_ready(core_ready),
        .tx        (tx),
        .frame_done(core_done),
        .busy      (core_busy)
    );

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph with 4-cycle bits and a 4-entry FIFO:
// register table, single/back-to-back frames, overflow, set-vs-clear and reset.
module tb_uart_tx_periph;

    localparam int          CPB  = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] TXD  = BASE + 32'h18;
    localparam logic [31:0] CON  = BASE + 32'h20;
    localparam int          STREAM_LEN = 1 + 5 * 10 * CPB + 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        bit          do_wr;
        logic [31:0] wa;
        logic [31:0] wd;
        bit          do_rd;
        logic [31:0] ra;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[10];
    logic stream[$];

    uart_tx_periph #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .MemWrite(MemWrite),
        .MemRead (MemRead),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .tx      (tx),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input string nm, input bit w, input logic [31:0] wa,
                                input logic [31:0] wd, input bit r, input logic [31:0] ra,
                                input logic [31:0] er, input logic ei);
        vec_t v;
        v.name = nm; v.do_wr = w; v.wa = wa; v.wd = wd;
        v.do_rd = r; v.ra = ra; v.exp_rdata = er; v.exp_irq = ei;
        return v;
    endfunction

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j < CPB) return 1'b0;
        if (j < 9 * CPB) return b[(j - CPB) / CPB];
        return 1'b1;
    endfunction

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; MemWrite = 1'b1;
        @(posedge clk); #1;
        MemWrite = 1'b0; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic bus_read(input string nm, input logic [31:0] a, input logic [31:0] exp);
        addr = a; MemRead = 1'b1; #1;
        check32(nm, rdata, exp);
        MemRead = 1'b0; addr = 32'h0;
    endtask

    task automatic expect_frame(input string nm, input logic [7:0] b, input logic exp_irq);
        for (int j = 0; j < 10 * CPB; j++) begin
            @(posedge clk); #1;
            check1($sformatf("%s_bit%0d", nm, j), tx, frame_bit(b, j));
            check1($sformatf("%s_irq%0d", nm, j), irq, exp_irq);
        end
    endtask

    initial begin
        rst = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; addr = 32'h0; wdata = 32'h0;

        tbl[0] = mk("con_irqen_set", 1, CON, 32'h1, 1, CON, 32'h1, 1'b0);
        tbl[1] = mk("con_irqen_clr", 1, CON, 32'h0, 1, CON, 32'h0, 1'b0);
        tbl[2] = mk("txd_read_zero", 0, 32'h0, 32'h0, 1, TXD, 32'h0, 1'b0);
        tbl[3] = mk("con_all_ones", 1, CON, 32'hFFFF_FFFF, 1, CON, 32'h1, 1'b0);
        tbl[4] = mk("con_no_memread", 0, 32'h0, 32'h0, 0, CON, 32'h0, 1'b0);
        tbl[5] = mk("con_w1c_only", 1, CON, 32'h24, 1, CON, 32'h0, 1'b0);
        tbl[6] = mk("alias_upper_wr", 1, 32'h5000_0020, 32'h1, 1, CON, 32'h0, 1'b0);
        tbl[7] = mk("unmapped_read", 1, CON, 32'h1, 1, BASE + 32'h24, 32'h0, 1'b0);
        tbl[8] = mk("misaligned_txd", 1, BASE + 32'h19, 32'h55, 1, CON, 32'h1, 1'b0);
        tbl[9] = mk("restore_con", 1, CON, 32'h0, 1, CON, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and 100 idle cycles
        check1("reset_tx", tx, 1'b1);
        check1("reset_irq", irq, 1'b0);
        bus_read("reset_con", CON, 32'h0);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            check1($sformatf("idle_tx%0d", i), tx, 1'b1);
            check1($sformatf("idle_irq%0d", i), irq, 1'b0);
        end
        bus_read("idle_con", CON, 32'h0);

        // Register table
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].do_wr) bus_write(tbl[i].wa, tbl[i].wd);
            addr = tbl[i].ra; MemRead = tbl[i].do_rd; #1;
            check32(tbl[i].name, rdata, tbl[i].exp_rdata);
            check1({tbl[i].name, "_irq"}, irq, tbl[i].exp_irq);
            MemRead = 1'b0; addr = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        check1("misaligned_not_sent", tx, 1'b1);

        // Single frame 0x55
        bus_write(TXD, 32'h55);
        check1("tx_before_fall", tx, 1'b1);
        bus_read("con_busy", CON, 32'h08);
        expect_frame("f55", 8'h55, 1'b0);
        @(posedge clk); #1;
        check1("f55_idle_after", tx, 1'b1);
        bus_read("f55_done", CON, 32'h04);
        addr = CON; MemRead = 1'b0; #1;
        check32("rdata_no_memread", rdata, 32'h0);
        addr = 32'h0;

        // Interrupt on completion, then W1C of done
        bus_write(CON, 32'h5);
        bus_read("irqen_only", CON, 32'h1);
        bus_write(TXD, 32'hA3);
        expect_frame("fA3", 8'hA3, 1'b0);
        @(posedge clk); #1;
        check1("irq_rise", irq, 1'b1);
        bus_read("fA3_con", CON, 32'h05);
        bus_write(CON, 32'h5);
        check1("irq_clear", irq, 1'b0);
        bus_read("done_clear_con", CON, 32'h01);

        // Back-to-back frames, full FIFO, overflow on sixth store
        bus_write(CON, 32'h0);
        fork
            begin
                for (int k = 0; k < STREAM_LEN; k++) begin
                    @(posedge clk); #1;
                    stream.push_back(tx);
                end
            end
            begin
                for (int b = 1; b <= 6; b++) bus_write(TXD, 32'(b));
                bus_read("full_ovf_con", CON, 32'h38);
            end
        join
        for (int k = 0; k < STREAM_LEN; k++) begin
            logic e;
            if (k == 0 || k > 5 * 10 * CPB) e = 1'b1;
            else e = frame_bit(8'((k - 1) / (10 * CPB) + 1), (k - 1) % (10 * CPB));
            check1($sformatf("stream%0d", k), stream[k], e);
        end
        bus_read("after_b2b_con", CON, 32'h24);
        bus_write(CON, 32'h20);
        bus_read("ovf_clear", CON, 32'h04);
        bus_write(CON, 32'h04);
        bus_read("done_clear2", CON, 32'h00);

        // done set on the same edge as a W1C of done: set wins
        bus_write(TXD, 32'h00);
        repeat (10 * CPB) @(posedge clk);
        #1;
        bus_write(CON, 32'h4);
        bus_read("set_beats_clear", CON, 32'h04);

        // Reset in the middle of DATA
        bus_write(CON, 32'h5);
        bus_read("pre_reset_con", CON, 32'h01);
        bus_write(TXD, 32'h00);
        bus_write(TXD, 32'h11);
        bus_write(TXD, 32'h22);
        repeat (8) @(posedge clk);
        #1;
        check1("mid_data_tx", tx, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check1("reset_tx_high", tx, 1'b1);
        check1("reset_irq_low", irq, 1'b0);
        rst = 1'b0;
        bus_read("post_reset_con", CON, 32'h0);
        begin
            int lows = 0;
            for (int i = 0; i < 20 * CPB; i++) begin
                @(posedge clk); #1;
                if (tx !== 1'b1) lows++;
            end
            check32("post_reset_quiet", 32'(lows), 32'h0);
        end
        bus_read("post_reset_con2", CON, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
